// File: rtl/map_pkg.sv
// Shared types for the map ROM arbiter: widths, owner tags, sequencer states.
package map_pkg;
   localparam int MAP_ADDR_W = 16;
   localparam int PIX_W = 24;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_RENDER,
      OWN_COLL
   } owner_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_DRAIN
   } arb_state_t;
endpackage

// File: rtl/map_rom_arbiter_if.sv
// Renderer and collision-checker read ports of the shared map ROM.
interface map_rom_arbiter_if;
   import map_pkg::*;

   logic                  render_req;
   logic [MAP_ADDR_W-1:0] render_addr;
   logic                  render_valid;
   logic [PIX_W-1:0]      render_data;
   logic                  coll_req;
   logic [MAP_ADDR_W-1:0] coll_addr;
   logic                  coll_gnt;
   logic                  coll_valid;
   logic [PIX_W-1:0]      coll_data;
   logic                  coll_starve;

   modport master (
      output render_req, render_addr,
      output coll_req, coll_addr,
      input  render_valid, render_data,
      input  coll_gnt, coll_valid, coll_data, coll_starve
   );

   modport slave (
      input  render_req, render_addr,
      input  coll_req, coll_addr,
      output render_valid, render_data,
      output coll_gnt, coll_valid, coll_data, coll_starve
   );
endinterface

// File: rtl/map_owner_pipe.sv
// Tracks which client owns each ROM read in flight; head lines up with rom_q.
module map_owner_pipe
   import map_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clock,
   input  logic   reset_n,
   input  owner_t tag_in,
   output owner_t head,
   output logic   empty
);

   owner_t pipe_q [DEPTH];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= OWN_NONE;
      end else begin
         pipe_q[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   always_comb begin
      empty = 1'b1;
      for (int i = 0; i < DEPTH; i++)
         if (pipe_q[i] != OWN_NONE) empty = 1'b0;
   end

   assign head = pipe_q[DEPTH-1];

endmodule

// File: rtl/map_rom_arbiter.sv
// Shares the dual-map pixel ROM between renderer and collision checker and
// sequences map changes so they land only at frame start with reads drained.
module map_rom_arbiter
   import map_pkg::*;
#(
   parameter int ROM_LAT    = 1,
   parameter int STARVE_LIM = 1024
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  frame_start,
   input  logic                  map_sel_req,
   input  logic                  map_sel_target,
   map_rom_arbiter_if.slave      bus,
   output logic [MAP_ADDR_W-1:0] rom_addr,
   output logic                  rom_sel,
   input  logic [PIX_W-1:0]      rom_q,
   output logic                  map_switched
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   arb_state_t       state, state_nx;
   owner_t           tag_in, head;
   logic             pipe_empty;
   logic             coll_blk, do_switch;
   logic             tgt_q, pend_vld_q, pend_tgt_q;
   logic             pend_any, pend_t, next_armed;
   logic [CNT_W-1:0] starve_cnt;

   always_comb begin
      bus.coll_gnt = bus.coll_req && !bus.render_req && !coll_blk;
      unique case (1'b1)
         bus.render_req: tag_in = OWN_RENDER;
         bus.coll_gnt:   tag_in = OWN_COLL;
         default:        tag_in = OWN_NONE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         rom_addr <= '0;
      else if (tag_in == OWN_RENDER)
         rom_addr <= bus.render_addr;
      else if (tag_in == OWN_COLL)
         rom_addr <= bus.coll_addr;
   end

   map_owner_pipe #(
      .DEPTH (ROM_LAT + 1)
   ) u_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .head    (head),
      .empty   (pipe_empty)
   );

   assign bus.render_valid = (head == OWN_RENDER);
   assign bus.coll_valid   = (head == OWN_COLL);
   assign bus.render_data  = rom_q;
   assign bus.coll_data    = rom_q;

   // A request arriving in the switch cycle counts as pending too.
   assign pend_any   = pend_vld_q || map_sel_req;
   assign pend_t     = map_sel_req ? map_sel_target : pend_tgt_q;
   assign next_armed = pend_any && (pend_t != tgt_q);

   always_ff @(posedge clock) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:
            if (map_sel_req && map_sel_target != rom_sel)
               state_nx = ST_ARMED;
         ST_ARMED:
            if (map_sel_req && map_sel_target == rom_sel)
               state_nx = ST_IDLE;
            else if (frame_start)
               state_nx = ST_DRAIN;
         ST_DRAIN:
            if (do_switch)
               state_nx = next_armed ? ST_ARMED : ST_IDLE;
         default:
            state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      coll_blk  = (state == ST_DRAIN);
      do_switch = coll_blk && pipe_empty && !bus.render_req;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tgt_q        <= 1'b0;
         pend_vld_q   <= 1'b0;
         pend_tgt_q   <= 1'b0;
         rom_sel      <= 1'b0;
         map_switched <= 1'b0;
      end else begin
         map_switched <= do_switch;
         if (do_switch) begin
            rom_sel    <= tgt_q;
            tgt_q      <= pend_t;
            pend_vld_q <= 1'b0;
         end else if (coll_blk && map_sel_req) begin
            pend_vld_q <= 1'b1;
            pend_tgt_q <= map_sel_target;
         end else if (map_sel_req) begin
            tgt_q <= map_sel_target;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         starve_cnt <= '0;
      else if (!bus.coll_req || bus.coll_gnt)
         starve_cnt <= '0;
      else if (starve_cnt < CNT_W'(STARVE_LIM))
         starve_cnt <= starve_cnt + 1'b1;
   end

   assign bus.coll_starve = (starve_cnt >= CNT_W'(STARVE_LIM));

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter with a one-cycle behavioural dual-map ROM.
module tb_map_rom_arbiter;
   import map_pkg::*;

   logic                  clock = 1'b0;
   logic                  reset_n;
   logic                  frame_start;
   logic                  map_sel_req;
   logic                  map_sel_target;
   logic [MAP_ADDR_W-1:0] rom_addr;
   logic                  rom_sel;
   logic [PIX_W-1:0]      rom_q;
   logic                  map_switched;
   int                    n_tests = 0;
   int                    n_fail = 0;

   map_rom_arbiter_if bus();

   map_rom_arbiter #(
      .ROM_LAT    (1),
      .STARVE_LIM (8)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .frame_start    (frame_start),
      .map_sel_req    (map_sel_req),
      .map_sel_target (map_sel_target),
      .bus            (bus),
      .rom_addr       (rom_addr),
      .rom_sel        (rom_sel),
      .rom_q          (rom_q),
      .map_switched   (map_switched)
   );

   always #5 clock = ~clock;

   function automatic logic [PIX_W-1:0] pix(input logic s,
                                            input logic [15:0] a);
      return {(s ? 8'hC3 : 8'h51), a};
   endfunction

   // map 1 / map 3 contents, registered read
   always @(posedge clock) rom_q <= pix(rom_sel, rom_addr);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_in();
      frame_start     = 1'b0;
      map_sel_req     = 1'b0;
      map_sel_target  = 1'b0;
      bus.render_req  = 1'b0;
      bus.render_addr = '0;
      bus.coll_req    = 1'b0;
      bus.coll_addr   = '0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      idle_in();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_rom_sel", rom_sel, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rvalid", bus.render_valid, 0);
      chk("rst_cvalid", bus.coll_valid, 0);
      chk("rst_gnt", bus.coll_gnt, 0);
      chk("rst_starve", bus.coll_starve, 0);
      chk("rst_switched", map_switched, 0);
      reset_n = 1'b1;

      // render burst 0x0010..0x0013
      for (int i = 0; i < 7; i++) begin
         idle_in();
         bus.render_req  = (i < 4);
         bus.render_addr = 16'h0010 + 16'(i);
         @(negedge clock);
         chk("t1_rvalid", bus.render_valid, (i >= 2 && i < 6));
         if (i >= 2 && i < 6)
            chk("t1_rdata", bus.render_data, pix(0, 16'h0010 + 16'(i - 2)));
         chk("t1_cvalid", bus.coll_valid, 0);
         next_cycle();
      end

      // collision waits behind five render cycles
      for (int i = 0; i < 9; i++) begin
         idle_in();
         bus.render_req  = (i < 5);
         bus.render_addr = 16'h0100 + 16'(i);
         bus.coll_req    = (i <= 5);
         bus.coll_addr   = 16'h1234;
         @(negedge clock);
         chk("t2_gnt", bus.coll_gnt, (i == 5));
         chk("t2_rvalid", bus.render_valid, (i >= 2 && i <= 6));
         chk("t2_cvalid", bus.coll_valid, (i == 7));
         if (i == 7) chk("t2_cdata", bus.coll_data, pix(0, 16'h1234));
         chk("t2_starve", bus.coll_starve, 0);
         next_cycle();
      end

      // map switch to map 3 with a collision read in flight
      for (int i = 0; i < 18; i++) begin
         idle_in();
         map_sel_req     = (i == 0);
         map_sel_target  = 1'b1;
         frame_start     = (i == 10);
         bus.coll_req    = (i == 9) || (i >= 11 && i <= 13);
         bus.coll_addr   = 16'h0042;
         bus.render_req  = (i == 14);
         @(negedge clock);
         chk("t3_gnt", bus.coll_gnt, (i == 9 || i == 13));
         chk("t3_cvalid", bus.coll_valid, (i == 11 || i == 15));
         if (i == 11) chk("t3_cdata_old", bus.coll_data, pix(0, 16'h0042));
         if (i == 15) chk("t3_cdata_new", bus.coll_data, pix(1, 16'h0042));
         chk("t3_rvalid", bus.render_valid, (i == 16));
         if (i == 16) chk("t3_rdata", bus.render_data, pix(1, 16'h0000));
         chk("t3_rom_sel", rom_sel, (i >= 13));
         chk("t3_switched", map_switched, (i == 13));
         next_cycle();
      end

      // starvation with STARVE_LIM = 8
      for (int i = 0; i < 13; i++) begin
         idle_in();
         bus.render_req  = (i < 10);
         bus.render_addr = 16'h0200 + 16'(i);
         bus.coll_req    = (i <= 10);
         bus.coll_addr   = 16'h0300;
         @(negedge clock);
         chk("t5_starve", bus.coll_starve, (i >= 8 && i <= 10));
         chk("t5_gnt", bus.coll_gnt, (i == 10));
         if (i == 12) begin
            chk("t5_cvalid", bus.coll_valid, 1);
            chk("t5_cdata", bus.coll_data, pix(1, 16'h0300));
         end
         next_cycle();
      end

      // reset while ARMED with a render read in flight
      for (int i = 0; i < 9; i++) begin
         idle_in();
         reset_n         = !(i == 2);
         map_sel_req     = (i == 0);
         map_sel_target  = 1'b0;
         bus.render_req  = (i == 1);
         bus.render_addr = 16'h0005;
         frame_start     = (i == 5);
         bus.coll_req    = (i == 6);
         bus.coll_addr   = 16'h0007;
         @(negedge clock);
         chk("t6_rvalid", bus.render_valid, 0);
         chk("t6_rom_sel", rom_sel, (i <= 2));
         if (i >= 3) begin
            chk("t6_switched", map_switched, 0);
            chk("t6_gnt", bus.coll_gnt, (i == 6));
            chk("t6_cvalid", bus.coll_valid, (i == 8));
         end
         next_cycle();
      end
      reset_n = 1'b1;

      // request then cancel before frame start
      for (int i = 0; i < 10; i++) begin
         idle_in();
         map_sel_req    = (i == 0 || i == 2);
         map_sel_target = (i == 0);
         frame_start    = (i == 4);
         bus.coll_req   = (i == 5);
         bus.coll_addr  = 16'h0009;
         @(negedge clock);
         chk("t4_rom_sel", rom_sel, 0);
         chk("t4_switched", map_switched, 0);
         chk("t4_gnt", bus.coll_gnt, (i == 5));
         next_cycle();
      end

      // map request coincident with frame start waits for the next one
      for (int i = 0; i < 8; i++) begin
         idle_in();
         map_sel_req    = (i == 0);
         map_sel_target = 1'b1;
         frame_start    = (i == 0 || i == 3);
         bus.coll_req   = (i == 1);
         bus.coll_addr  = 16'h0011;
         @(negedge clock);
         chk("t7_rom_sel", rom_sel, (i >= 5));
         chk("t7_switched", map_switched, (i == 5));
         chk("t7_gnt", bus.coll_gnt, (i == 1));
         chk("t7_cvalid", bus.coll_valid, (i == 3));
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
